// File: rtl/lockable_reg_bank_ctrl.sv
// Two-requester round-robin arbiter in front of a bank of sticky-lockable config registers.
// Commands run IDLE -> EXEC -> RESP; locked or out-of-range targets get an error response.
module lockable_reg_bank_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_a,
  input  logic                       op_a,
  input  logic [ADDR_W-1:0]          addr_a,
  input  logic [DATA_W-1:0]          wdata_a,
  output logic                       ack_a,
  output logic                       err_a,
  input  logic                       req_b,
  input  logic                       op_b,
  input  logic [ADDR_W-1:0]          addr_b,
  input  logic [DATA_W-1:0]          wdata_b,
  output logic                       ack_b,
  output logic                       err_b,
  input  logic                       global_lock,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        lock_q,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [ADDR_W:0] NREGS_W = (ADDR_W+1)'(NUM_REGS);

  state_t                     state_q, state_d;
  logic                       rr_prio_q, rr_prio_d;  // 0 = A has priority, 1 = B
  logic                       win_q, win_d;          // 0 = A, 1 = B
  logic                       op_q, op_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;
  logic                       err_q, err_d;
  logic [NUM_REGS*DATA_W-1:0] reg_d;
  logic [NUM_REGS-1:0]        lock_d;
  logic                       grant_b;
  logic                       in_range;
  logic                       locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_prio_q <= 1'b0;
      win_q     <= 1'b0;
      op_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      reg_q     <= '0;
      lock_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_prio_q <= rr_prio_d;
      win_q     <= win_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      reg_q     <= reg_d;
      lock_q    <= lock_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_prio_d = rr_prio_q;
    win_d     = win_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    reg_d     = reg_q;
    lock_d    = lock_q;
    locked    = 1'b0;
    grant_b   = req_b & (~req_a | rr_prio_q);
    in_range  = ({1'b0, addr_q} < NREGS_W);

    case (state_q)
      IDLE: begin
        if (req_a | req_b) begin
          win_d     = grant_b;
          op_d      = grant_b ? op_b    : op_a;
          addr_d    = grant_b ? addr_b  : addr_a;
          wdata_d   = grant_b ? wdata_b : wdata_a;
          rr_prio_d = ~grant_b;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
        if (!in_range) begin
          err_d = 1'b1;
        end else begin
          // global_lock seen in this same cycle already blocks the write
          locked = lock_q[addr_q] | global_lock;
          if (op_q) begin
            lock_d[addr_q] = 1'b1;
            err_d          = 1'b0;
          end else if (locked) begin
            err_d = 1'b1;
          end else begin
            reg_d[addr_q*DATA_W +: DATA_W] = wdata_q;
            err_d                          = 1'b0;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (global_lock) lock_d = '1;
  end

  assign ack_a = (state_q == RESP) & ~win_q;
  assign ack_b = (state_q == RESP) &  win_q;
  assign err_a = ack_a & err_q;
  assign err_b = ack_b & err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_lockable_reg_bank_ctrl.sv
// Randomized bench for lockable_reg_bank_ctrl against a transaction-level register/lock model.
module tb_lockable_reg_bank_ctrl;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req_a, op_a, req_b, op_b, ack_a, err_a, ack_b, err_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          global_lock, busy;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    lock_q;

  logic          req3, op3, ack3_a, err3_a, ack3_b, err3_b, busy3;
  logic [AW-1:0] addr3;
  logic [DW-1:0] wdata3;
  logic [3*DW-1:0] reg3_q;
  logic [2:0]      lock3_q;

  lockable_reg_bank_ctrl #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .op_a(op_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a), .err_a(err_a),
    .req_b(req_b), .op_b(op_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b), .err_b(err_b),
    .global_lock(global_lock), .reg_q(reg_q), .lock_q(lock_q), .busy(busy)
  );

  lockable_reg_bank_ctrl #(.NUM_REGS(3), .DATA_W(DW), .ADDR_W(AW)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req3), .op_a(op3), .addr_a(addr3), .wdata_a(wdata3), .ack_a(ack3_a), .err_a(err3_a),
    .req_b(1'b0), .op_b(1'b0), .addr_b(2'd0), .wdata_b(8'd0), .ack_b(ack3_b), .err_b(err3_b),
    .global_lock(1'b0), .reg_q(reg3_q), .lock_q(lock3_q), .busy(busy3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: register contents, lock bits, next priority (0 = A)
  logic [DW-1:0] m_reg[NR];
  logic [NR-1:0] m_lock;
  bit            m_rr;

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    m_lock = '0;
    m_rr   = 1'b0;
  endtask

  task automatic m_exec(input bit op, input int a, input logic [DW-1:0] d, input bit gl, output bit err);
    if (a >= NR) err = 1'b1;
    else if (op) begin m_lock[a] = 1'b1; err = 1'b0; end
    else if (m_lock[a] || gl) err = 1'b1;
    else begin m_reg[a] = d; err = 1'b0; end
    if (gl) m_lock = '1;
  endtask

  function automatic logic [31:0] m_flat();
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_reg[i];
    return f;
  endfunction

  task automatic drive(input bit who, input bit r, input bit op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!who) begin req_a = r; op_a = op; addr_a = a; wdata_a = d; end
    else      begin req_b = r; op_b = op; addr_b = a; wdata_b = d; end
  endtask

  task automatic check_state();
    chk("reg_q", reg_q, m_flat());
    chk("lock_q", 32'(lock_q), 32'(m_lock));
  endtask

  task automatic wait_ack(input bit who, input bit gl_exec, output int lat);
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      global_lock = gl_exec && (c == 1);
      chk("ack_excl", 32'(ack_a & ack_b), 32'd0);
      if (who ? ack_b : ack_a) begin lat = c; break; end
    end
  endtask

  task automatic run_single(input bit who, input bit op, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit gl_exec);
    bit exp_err;
    int lat;
    @(negedge clk);
    drive(who, 1'b1, op, a, d);
    m_exec(op, int'(a), d, gl_exec, exp_err);
    m_rr = ~who;
    wait_ack(who, gl_exec, lat);
    chk("lat1", lat, 32'd2);
    chk("err1", 32'(who ? err_b : err_a), 32'(exp_err));
    chk("other_ack1", 32'(who ? ack_a : ack_b), 32'd0);
    drive(who, 1'b0, op, a, d);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    check_state();
  endtask

  task automatic run_both(input bit op0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input bit op1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bit first, second, e1, e2;
    int lat;
    @(negedge clk);
    drive(1'b0, 1'b1, op0, a0, d0);
    drive(1'b1, 1'b1, op1, a1, d1);
    first  = m_rr;
    second = ~first;
    if (!first) m_exec(op0, int'(a0), d0, 1'b0, e1);
    else        m_exec(op1, int'(a1), d1, 1'b0, e1);
    wait_ack(first, 1'b0, lat);
    chk("both_lat1", lat, 32'd2);
    chk("both_err1", 32'(first ? err_b : err_a), 32'(e1));
    chk("both_other1", 32'(first ? ack_a : ack_b), 32'd0);
    if (!first) drive(1'b0, 1'b0, op0, a0, d0);
    else        drive(1'b1, 1'b0, op1, a1, d1);
    if (!second) m_exec(op0, int'(a0), d0, 1'b0, e2);
    else         m_exec(op1, int'(a1), d1, 1'b0, e2);
    m_rr = first;
    wait_ack(second, 1'b0, lat);
    chk("both_lat2", lat, 32'd3);
    chk("both_err2", 32'(second ? err_b : err_a), 32'(e2));
    chk("both_other2", 32'(second ? ack_a : ack_b), 32'd0);
    if (!second) drive(1'b0, 1'b0, op0, a0, d0);
    else         drive(1'b1, 1'b0, op1, a1, d1);
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    global_lock = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state();
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    req_a = 0; op_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; op_b = 0; addr_b = '0; wdata_b = '0;
    req3 = 0; op3 = 0; addr3 = '0; wdata3 = '0;
    global_lock = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_reg", reg_q, 32'd0);
    chk("rst_lock", 32'(lock_q), 32'd0);
    chk("rst_ack", 32'({ack_a, ack_b, err_a, err_b, busy}), 32'd0);
    rst_n = 1'b1;

    run_single(1'b0, 1'b0, 2'd1, 8'h5A, 1'b0);
    chk("t1_reg", reg_q, 32'h0000_5A00);
    run_single(1'b0, 1'b1, 2'd2, 8'h00, 1'b0);
    run_single(1'b1, 1'b0, 2'd2, 8'hFF, 1'b0);
    chk("t2_lock", 32'(lock_q), 32'h4);
    chk("t2_reg", reg_q, 32'h0000_5A00);
    run_both(1'b0, 2'd0, 8'h11, 1'b0, 2'd3, 8'h33);
    run_both(1'b0, 2'd3, 8'h44, 1'b0, 2'd0, 8'h55);

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 2)
        run_both($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), 8'($urandom),
                 $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), 8'($urandom));
      else
        run_single(kind[0], $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    do_reset();
    run_single(1'b0, 1'b0, 2'd3, 8'hC3, 1'b1);
    chk("gl_exec_reg3", 32'(reg_q[3*DW +: DW]), 32'd0);
    chk("gl_exec_lock", 32'(lock_q), 32'hF);

    do_reset();
    @(negedge clk);
    global_lock = 1'b1;
    m_lock = '1;
    @(negedge clk);
    global_lock = 1'b0;
    chk("glp_lock", 32'(lock_q), 32'hF);
    @(negedge clk);
    chk("glp_sticky", 32'(lock_q), 32'hF);
    run_single(1'b1, 1'b0, 2'd0, 8'h99, 1'b0);

    // 3-register instance: out-of-range address, then reset during EXEC
    @(negedge clk);
    req3 = 1'b1; op3 = 1'b0; addr3 = 2'd3; wdata3 = 8'h77;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ack3_a) begin lat = c; break; end
    end
    chk("r3_lat", lat, 32'd2);
    chk("r3_err", 32'(err3_a), 32'd1);
    req3 = 1'b0;
    @(negedge clk);
    chk("r3_reg", 32'(reg3_q), 32'd0);

    req3 = 1'b1; addr3 = 2'd0; wdata3 = 8'h11;
    @(negedge clk);
    chk("r3_busy_exec", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    req3 = 1'b0;
    m_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("r3_noack", 32'(ack3_a), 32'd0);
    end
    chk("r3_rst_reg", 32'(reg3_q), 32'd0);
    chk("r3_rst_lock", 32'(lock3_q), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("r3_postrst_ack", 32'(ack3_a), 32'd0);
    check_state();
    req3 = 1'b1; addr3 = 2'd1; wdata3 = 8'h22;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ack3_a) begin lat = c; break; end
    end
    chk("r3_w_lat", lat, 32'd2);
    chk("r3_w_err", 32'(err3_a), 32'd0);
    req3 = 1'b0;
    @(negedge clk);
    chk("r3_w_reg", 32'(reg3_q), 32'h00_2200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
